// File: rtl/pe_lsb_isolate.sv
// rtl/pe_lsb_isolate.sv - combinational one-hot isolation of the lowest set bit
//
// Ports:
//   data_i  [WIDTH]  input word
//   lsb_o   [WIDTH]  one-hot mask of the lowest set bit of data_i, zero if data_i is zero
module pe_lsb_isolate #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] lsb_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Two's complement negate keeps the lowest one and clears every bit below
    // it; the bits above it come out inverted, so the AND leaves only that bit.
    always_comb begin
        lsb_o = data_i & (~data_i + ONE);
    end

endmodule

// File: rtl/priority_encoder.sv
// rtl/priority_encoder.sv - registered leading/trailing one-hot priority isolator
//
// Ports:
//   clk_i         clock, all state updates on the rising edge
//   srst_i        asynchronous active-low reset, clears both pipeline stages
//   data_i        [WIDTH] input word, registered in stage 1
//   data_left_o   [WIDTH] one-hot mask of the highest set bit, zero if none
//   data_right_o  [WIDTH] one-hot mask of the lowest set bit, zero if none
// Latency is two clocks; a word sampled at edge N is on the outputs after edge N+1.
module priority_encoder #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_left_o,
    output logic [WIDTH-1:0] data_right_o
);

    logic [WIDTH-1:0] in_d;
    logic [WIDTH-1:0] in_q;
    logic [WIDTH-1:0] left_d;
    logic [WIDTH-1:0] left_q;
    logic [WIDTH-1:0] right_d;
    logic [WIDTH-1:0] right_q;
    logic [WIDTH-1:0] in_rev;
    logic [WIDTH-1:0] left_rev;

    always_comb begin
        in_d = data_i;
    end

    pe_lsb_isolate #(
        .WIDTH (WIDTH)
    ) u_right (
        .data_i (in_q),
        .lsb_o  (right_d)
    );

    // The highest set bit is the lowest set bit of the mirrored word; mirror
    // the input, isolate, then mirror the one-hot mask back.
    always_comb begin
        in_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            in_rev[i] = in_q[WIDTH-1-i];
        end
    end

    pe_lsb_isolate #(
        .WIDTH (WIDTH)
    ) u_left (
        .data_i (in_rev),
        .lsb_o  (left_rev)
    );

    always_comb begin
        left_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            left_d[i] = left_rev[WIDTH-1-i];
        end
    end

    always_ff @(posedge clk_i or negedge srst_i) begin
        if (!srst_i) begin
            in_q    <= '0;
            left_q  <= '0;
            right_q <= '0;
        end else begin
            in_q    <= in_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    assign data_left_o  = left_q;
    assign data_right_o = right_q;

endmodule

// File: tb/tb_priority_encoder.sv
// tb/tb_priority_encoder.sv - self-checking bench for priority_encoder
module tb_priority_encoder;

    localparam int W = 8;

    logic         clk_i;
    logic         srst_i;
    logic [W-1:0] data_i;
    logic [W-1:0] data_left_o;
    logic [W-1:0] data_right_o;

    int n_cmp = 0;
    int n_bad = 0;
    bit run_cmp = 0;

    logic [W-1:0] hist0;
    logic [W-1:0] hist1;

    priority_encoder #(
        .WIDTH (W)
    ) dut (
        .clk_i        (clk_i),
        .srst_i       (srst_i),
        .data_i       (data_i),
        .data_left_o  (data_left_o),
        .data_right_o (data_right_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [W-1:0] model_left(input logic [W-1:0] x);
        logic [W-1:0] r;
        r = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (x[i]) begin
                r = '0;
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] model_right(input logic [W-1:0] x);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (x[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    function automatic int popcount(input logic [W-1:0] x);
        int c;
        c = 0;
        for (int i = 0; i < W; i++) c += int'(x[i]);
        return c;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference history: input words seen at the last two rising edges.
    always @(posedge clk_i or negedge srst_i) begin
        if (!srst_i) begin
            hist0 <= '0;
            hist1 <= '0;
        end else begin
            hist1 <= hist0;
            hist0 <= data_i;
        end
    end

    always @(negedge clk_i) begin
        if (run_cmp) begin
            chk("stream_left", data_left_o, model_left(hist1));
            chk("stream_right", data_right_o, model_right(hist1));
            n_cmp++;
            if (popcount(data_left_o) > 1 || popcount(data_right_o) > 1) begin
                n_bad++;
                $display("FAIL onehot: left %h right %h not one-hot or zero", data_left_o, data_right_o);
            end
        end
    end

    task automatic apply_check(input string name, input logic [W-1:0] d,
                               input logic [W-1:0] el, input logic [W-1:0] er);
        @(negedge clk_i);
        data_i = d;
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        chk({name, "_left"}, data_left_o, el);
        chk({name, "_right"}, data_right_o, er);
    endtask

    logic [W-1:0] s_in  [3];
    logic [W-1:0] s_l   [3];
    logic [W-1:0] s_r   [3];
    logic [W-1:0] rnd;

    initial begin
        s_in = '{8'h0A, 8'h50, 8'h3C};
        s_l  = '{8'h08, 8'h40, 8'h20};
        s_r  = '{8'h02, 8'h10, 8'h04};

        chk("model_l_2C", model_left(8'h2C), 8'h20);
        chk("model_r_2C", model_right(8'h2C), 8'h04);
        chk("model_l_81", model_left(8'h81), 8'h80);
        chk("model_r_00", model_right(8'h00), 8'h00);

        srst_i = 1'b0;
        data_i = 8'hFF;
        #1;
        chk("rst_left", data_left_o, 8'h00);
        chk("rst_right", data_right_o, 8'h00);
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_hold_left", data_left_o, 8'h00);
        chk("rst_hold_right", data_right_o, 8'h00);
        srst_i = 1'b1;
        run_cmp = 1;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("post_rst1_left", data_left_o, 8'h00);
        chk("post_rst1_right", data_right_o, 8'h00);

        apply_check("t2C", 8'b0010_1100, 8'b0010_0000, 8'b0000_0100);
        apply_check("t00", 8'h00, 8'h00, 8'h00);
        apply_check("t80", 8'h80, 8'h80, 8'h80);
        apply_check("t01", 8'h01, 8'h01, 8'h01);
        apply_check("tFF", 8'hFF, 8'h80, 8'h01);
        apply_check("t81", 8'h81, 8'h80, 8'h01);

        @(negedge clk_i);
        for (int i = 0; i < 3; i++) begin
            data_i = s_in[i];
            @(posedge clk_i);
            @(negedge clk_i);
            if (i >= 1) begin
                chk("burst_left", data_left_o, s_l[i-1]);
                chk("burst_right", data_right_o, s_r[i-1]);
            end
        end
        data_i = 8'h00;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("burst_left", data_left_o, s_l[2]);
        chk("burst_right", data_right_o, s_r[2]);

        data_i = 8'hFF;
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        #2;
        srst_i = 1'b0;
        #1;
        chk("async_rst_left", data_left_o, 8'h00);
        chk("async_rst_right", data_right_o, 8'h00);
        #1;
        srst_i = 1'b1;

        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_i);
            case ($urandom_range(0, 3))
                0:       rnd = 8'h00;
                1:       rnd = 8'h01 << $urandom_range(0, W - 1);
                default: rnd = W'($urandom);
            endcase
            data_i = rnd;
        end
        @(negedge clk_i);
        @(negedge clk_i);
        @(negedge clk_i);
        run_cmp = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
